pakin_io: RTL

Debug packet sink for the b_fifo test: the downstream stage of the debug packet source. It accepts packets on one input channel with a 4-phase req/ack handshake and buffers them in a small FIFO. Each packet is checked against the source's generation pattern (fixed src, rotating dst, incrementing data nibble, fixed redundancy), and the block raises sticky error flags plus a receive counter for board-level debug.

---
 rtl/pakin_io_pkg.sv | 19 +
 rtl/pak_fifo.sv | 45 ++++
 rtl/pakin_io.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pakin_io_pkg.sv
// Shared field widths, handshake state encoding and the dst rotation rule
// used by both the debug packet source and this sink.
package pakin_io_pkg;

    localparam int NS_ADDRESS_SIZE = 4;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

    // Next destination in the source's rotation: wraps to lo once hi is reached.
    function automatic int next_addr(input int a, input int lo, input int hi);
        return (a >= hi) ? lo : a + 1;
    endfunction

endpackage

// File: rtl/pak_fifo.sv
// Synchronous FIFO holding packed packets; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module pak_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_rdata = mem_q[rptr_q[AW-1:0]];

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is left unreset; the pointers alone define which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/pakin_io.sv
// Debug packet sink: 4-phase req/ack receiver feeding a small FIFO, with a
// checker for the source's generation pattern, sticky error flags and a counter.
module pakin_io
    import pakin_io_pkg::*;
#(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 3,
    parameter int CHK_SRC  = 3,
    parameter int CHK_RED  = 15,
    parameter int DEPTH    = 4,
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int RSZ      = NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic           o_pkt_vld,
    output logic [ASZ-1:0] o_pkt_src,
    output logic [ASZ-1:0] o_pkt_dst,
    output logic [DSZ-1:0] o_pkt_dat,
    output logic [RSZ-1:0] o_pkt_red,
    input  logic           i_pkt_pop,
    output logic           dbg_full,
    output logic [7:0]     dbg_cnt,
    output logic [3:0]     dbg_err
);

    localparam int PW = 2*ASZ + DSZ + RSZ;

    rx_state_e      state_q, state_d;
    logic           push;
    logic           fifo_full, fifo_empty;
    logic [PW-1:0]  head;

    logic           first_q, first_d;
    logic [ASZ-1:0] prev_dst_q, prev_dst_d;
    logic [3:0]     prev_nib_q, prev_nib_d;
    logic [3:0]     err_q, err_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [ASZ-1:0] exp_dst;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE: if (push)    state_d = RX_ACK;
            RX_ACK:  if (!i0_req) state_d = RX_IDLE;
            default:              state_d = RX_IDLE;
        endcase
    end

    // Acceptance uses the pre-pop full flag, so a pop never lets a push through in the same cycle.
    always_comb begin
        i0_ack = (state_q == RX_ACK);
        push   = (state_q == RX_IDLE) && i0_req && !fifo_full;
    end

    pak_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (i_pkt_pop),
        .i_wdata ({i0_src, i0_dst, i0_dat, i0_red}),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign exp_dst = ASZ'(next_addr(int'(prev_dst_q), MIN_ADDR, MAX_ADDR));

    always_comb begin
        first_d    = first_q;
        prev_dst_d = prev_dst_q;
        prev_nib_d = prev_nib_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (push) begin
            cnt_d      = cnt_q + 8'd1;
            first_d    = 1'b0;
            prev_dst_d = i0_dst;
            prev_nib_d = i0_dat[3:0];
            if (i0_src != ASZ'(CHK_SRC)) err_d[0] = 1'b1;
            if (i0_red != RSZ'(CHK_RED)) err_d[3] = 1'b1;
            // The first packet since reset only seeds the rotation and data references.
            if (!first_q) begin
                if (i0_dst != exp_dst)                err_d[1] = 1'b1;
                if (i0_dat[3:0] != prev_nib_q + 4'd1) err_d[2] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            first_q    <= 1'b1;
            prev_dst_q <= '0;
            prev_nib_q <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            first_q    <= first_d;
            prev_dst_q <= prev_dst_d;
            prev_nib_q <= prev_nib_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_pkt_vld = !fifo_empty;
    assign {o_pkt_src, o_pkt_dst, o_pkt_dat, o_pkt_red} = head;
    assign dbg_full  = fifo_full;
    assign dbg_cnt   = cnt_q;
    assign dbg_err   = err_q;

endmodule
